conv_window_scheduler: RTL
==========================

Name: conv_window_scheduler

Overview:
- Sequences one 3x3 "valid" convolution over an IMG_W x IMG_H image stored in an input memory.
- For each output pixel:
  - fetches the 9-pixel window into a param9 register;
  - starts the external MAC unit and waits for its result;
  - writes the result to an output memory.
- Holds the 9 kernel weights, loaded through a configuration port, and drives them to the MAC.
- Sits between the image/result memories and the MAC datapath.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- MAC_LAT, 12, cycles from the mac_start pulse to when mac_result is valid
- AW, $clog2(IMG_W*IMG_H), address width for both memories

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- go  in  1  start-convolution request, sampled in IDLE only
- busy  out  1  high from go acceptance until after the last write
- conv_done  out  1  one-cycle pulse after the last output write
- w_we  in  1  weight write strobe, ignored while busy
- w_idx  in  4  weight index 0..8; 9..15 ignored
- w_data  in  NBITS  signed weight
- in_addr  out  AW  input memory read address (row-major)
- in_rdata  in  NBITS  read data, valid 1 cycle after in_addr
- mac_inputs  out  param9  fetched window
- mac_weights  out  param9  weight registers
- mac_start  out  1  one-cycle MAC start pulse
- mac_done  in  1  MAC completion level; may stay high between operations
- mac_result  in  regC  MAC result
- out_we  out  1  output write strobe
- out_addr  out  AW  (oy*(IMG_W-2)+ox)
- out_data  out  regC  value written

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state IDLE;
  - busy, conv_done, mac_start, out_we = 0;
  - in_addr, out_addr, out_data = 0;
  - window and weight registers = 0;
  - ox, oy = 0.
- Reset mid-operation aborts immediately. No further writes occur and weights are cleared.
- Weight load: in IDLE, w_we with w_idx<9 writes w_data into weights9[w_idx] at the clock edge.
- States:
  - IDLE: go=1 -> FETCH with ox=oy=0, busy=1 from the next cycle.
  - FETCH:
    - Issue 9 reads, k=0..8, one per cycle: in_addr=(oy+k/3)*IMG_W+ox+k%3.
    - Capture in_rdata into inputs9[k] one cycle after each read.
    - 10 cycles total, then -> START.
  - START: mac_start=1 for exactly one cycle; wait counter cleared -> WAIT.
  - WAIT:
    - Counter increments each cycle.
    - Leave when counter>=MAC_LAT AND mac_done==1 -> WRITE.
    - If mac_done is still 0 at MAC_LAT, keep waiting; there is no timeout.
  - WRITE: out_we=1 for one cycle, out_data=mac_result, out_addr from ox/oy -> NEXT.
  - NEXT:
    - If ox<IMG_W-3: ox++.
    - Else: ox=0 and oy++.
    - If the last pixel (ox=IMG_W-3, oy=IMG_H-3) was just written -> FINISH, otherwise -> FETCH.
  - FINISH: conv_done=1 for one cycle, busy=0 -> IDLE.
- Per-pixel latency: 10+1+MAC_LAT+1+1 = 25 cycles at the default MAC_LAT.
- go while busy is ignored. w_we while busy is ignored.
- mac_inputs/mac_weights stay stable from START until WRITE.
- Outputs are written in row-major order; total writes = (IMG_W-2)*(IMG_H-2).

Optional Feature:
- Macro CONV_RELU_EN:
  - Defined: out_data = (mac_result<0) ? 0 : mac_result.
  - Undefined: out_data = mac_result unmodified.
- Timing is identical either way.

Decomposition:
- packConv holds the shared definitions:
  - NBITS, param9 (9 x signed NBITS), regC;
  - the scheduler state enum;
  - the window-offset constant table (row/col offsets for k=0..8).
- One natural sub-module: conv_addr_gen. Combinational; maps (ox, oy, k) to in_addr and (ox, oy) to out_addr. It is reused by future pooling controllers.

Test Plan:
- Load all weights=1; 4x4 image all pixels=1; go -> 4 writes, out_addr 0,1,2,3, out_data=9 each; conv_done one cycle after the 4th write; busy low after.
- Weights=identity (w[4]=1, others 0); 5x5 image pixel=addr -> out_data 6,7,8,11,12,13,16,17,18 at out_addr 0..8.
- Model the MAC with mac_done held high permanently -> every write occurs exactly 25 cycles apart; mac_start pulses exactly 9 times.
- Model the MAC with done delayed to MAC_LAT+5 -> WRITE delayed 5 cycles; go and w_we pulses during busy have no effect (weights unchanged, no restart).
- Assert reset=0 during the 2nd WAIT on 4x4 -> next cycle IDLE, busy=0, weights=0, no further out_we; a new go yields all-zero outputs.
- CONV_RELU_EN defined: weights all -1, pixels 1 -> out_data=0. Undefined: out_data=-9.

Source files
------------

// File: rtl/conv_window_scheduler_pkg.sv
// Shared types for the 3x3 convolution scheduler and its address generator.
// Window offsets are listed in row-major order, k = 0..8.
package packConv;

    localparam int NBITS = 16;
    localparam int CBITS = 2 * NBITS + 4;

    typedef logic signed [NBITS-1:0] pix_t;
    typedef pix_t [8:0] param9;
    typedef logic signed [CBITS-1:0] regC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [1:0] ROW_OFF [9] = '{
        2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2
    };
    localparam logic [1:0] COL_OFF [9] = '{
        2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2
    };

endpackage

// File: rtl/conv_window_scheduler_addr_gen.sv
// Combinational address mapping: (ox, oy, k) -> input read address and
// (ox, oy) -> output write address for a 3x3 valid window.
module conv_addr_gen
    import packConv::*;
#(
    parameter int IMG_W = 8,
    parameter int AW    = 6
) (
    input  logic [AW-1:0] ox,
    input  logic [AW-1:0] oy,
    input  logic [3:0]    k,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] out_addr
);

    logic [3:0] kk;
    int         row;
    int         col;

    always_comb begin
        kk       = (k > 4'd8) ? 4'd0 : k;
        row      = int'(oy) + int'(ROW_OFF[kk]);
        col      = int'(ox) + int'(COL_OFF[kk]);
        in_addr  = AW'(row * IMG_W + col);
        out_addr = AW'(int'(oy) * (IMG_W - 2) + int'(ox));
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// 3x3 valid-convolution scheduler: window fetch, MAC handshake, result write.
// Optional CONV_RELU_EN clamps negative results to zero on write.
module conv_window_scheduler
    import packConv::*;
#(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int MAC_LAT = 12,
    parameter int AW      = $clog2(IMG_W * IMG_H)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    output logic                    busy,
    output logic                    conv_done,
    input  logic                    w_we,
    input  logic [3:0]              w_idx,
    input  logic signed [NBITS-1:0] w_data,
    output logic [AW-1:0]           in_addr,
    input  logic signed [NBITS-1:0] in_rdata,
    output param9                   mac_inputs,
    output param9                   mac_weights,
    output logic                    mac_start,
    input  logic                    mac_done,
    input  regC                     mac_result,
    output logic                    out_we,
    output logic [AW-1:0]           out_addr,
    output regC                     out_data
);

    localparam int WCW = $clog2(MAC_LAT + 1) + 1;
    localparam logic [AW-1:0] OX_LAST = AW'(IMG_W - 3);
    localparam logic [AW-1:0] OY_LAST = AW'(IMG_H - 3);

    state_t         state;
    state_t         state_nx;
    logic [AW-1:0]  ox;
    logic [AW-1:0]  oy;
    logic [3:0]     fcnt;
    logic [WCW-1:0] wcnt;
    param9          win;
    param9          wts;
    logic           last_px;
    logic           lat_met;
    regC            act;

    conv_addr_gen #(
        .IMG_W(IMG_W),
        .AW   (AW)
    ) u_addr (
        .ox      (ox),
        .oy      (oy),
        .k       (fcnt),
        .in_addr (in_addr),
        .out_addr(out_addr)
    );

    assign last_px     = (ox == OX_LAST) && (oy == OY_LAST);
    assign lat_met     = (int'(wcnt) + 1) >= MAC_LAT;
    assign mac_inputs  = win;
    assign mac_weights = wts;

    assign busy      = (state != S_IDLE) && (state != S_FINISH);
    assign mac_start = (state == S_START);
    assign out_we    = (state == S_WRITE);
    assign conv_done = (state == S_FINISH);

`ifdef CONV_RELU_EN
    assign act = mac_result[CBITS-1] ? '0 : mac_result;
`else
    assign act = mac_result;
`endif
    assign out_data = out_we ? act : '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (go) state_nx = S_FETCH;
            S_FETCH:  if (fcnt == 4'd9) state_nx = S_START;
            S_START:  state_nx = S_WAIT;
            S_WAIT:   if (lat_met && mac_done) state_nx = S_WRITE;
            S_WRITE:  state_nx = S_NEXT;
            S_NEXT:   state_nx = last_px ? S_FINISH : S_FETCH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Read k issues in fetch cycle k; its data lands one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            ox    <= '0;
            oy    <= '0;
            fcnt  <= '0;
            wcnt  <= '0;
            win   <= '0;
            wts   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        ox   <= '0;
                        oy   <= '0;
                        fcnt <= '0;
                    end
                    if (w_we && (w_idx < 4'd9))
                        wts[w_idx] <= w_data;
                end
                S_FETCH: begin
                    fcnt <= fcnt + 4'd1;
                    if (fcnt != 4'd0)
                        win[fcnt - 4'd1] <= in_rdata;
                end
                S_START: wcnt <= '0;
                S_WAIT: begin
                    if (int'(wcnt) < MAC_LAT)
                        wcnt <= wcnt + WCW'(1);
                end
                S_NEXT: begin
                    fcnt <= '0;
                    if (last_px) begin
                        ox <= '0;
                        oy <= '0;
                    end else if (ox < OX_LAST) begin
                        ox <= ox + AW'(1);
                    end else begin
                        ox <= '0;
                        oy <= oy + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
